// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline.
//
// Tracks the destination registers of the instructions in EX and MEM. It
// latches the EX-stage operand mux3 selects when an instruction moves from
// ID into EX. It stalls IF/ID for one cycle on a load-use hazard, and it
// sequences the IF/ID and ID/EX flushes after a taken branch.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   id_*                  decoded fields of the instruction in ID
//   branch_taken          branch resolved taken in EX this cycle
//   stall                 hold PC and IF/ID (combinational)
//   flush_if_id           zero the IF/ID register (combinational)
//   flush_id_ex           bubble into ID/EX on a taken branch (combinational)
//   fwd_a, fwd_b          operand mux3 selects for the instruction in EX
//                         (00 regfile, 10 EX/MEM, 01 MEM/WB)
//   hazard_cnt            saturating count of stall/flush cycles
module hazard_forward_ctrl #(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              branch_taken,
  output logic              stall,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  hazard_cnt
);

  localparam logic [0:0] StRun       = 1'b0;
  localparam logic [0:0] StLoadStall = 1'b1;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } slot_t;

  // The WB slot needs no storage here: the register file writes before it
  // reads, so an instruction in WB never needs forwarding.
  slot_t             ex_q, ex_d, mem_q;
  logic [0:0]        state_q, state_d;
  logic [1:0]        flush_cnt_q, flush_cnt_d;
  logic [1:0]        fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic id_ok;
  logic ex_m_rs1, ex_m_rs2, mem_m_rs1, mem_m_rs2;
  logic load_use, advance;

  function automatic logic slot_match(slot_t s, logic [REG_AW-1:0] r, logic use_r);
    return s.valid & s.regwrite & (s.rd != '0) & (s.rd == r) & use_r;
  endfunction

  assign id_ok     = id_valid & (flush_cnt_q == 2'd0);
  assign ex_m_rs1  = id_ok & slot_match(ex_q, id_rs1, id_use_rs1);
  assign ex_m_rs2  = id_ok & slot_match(ex_q, id_rs2, id_use_rs2);
  assign mem_m_rs1 = id_ok & slot_match(mem_q, id_rs1, id_use_rs1);
  assign mem_m_rs2 = id_ok & slot_match(mem_q, id_rs2, id_use_rs2);

  // In the load-stall state the load has already moved on to MEM.
  assign load_use = (state_q == StRun) & ex_q.memread & (ex_m_rs1 | ex_m_rs2);

  // A taken branch overrides a load-use hazard.
  assign stall       = ~reset & load_use & ~branch_taken;
  assign flush_if_id = ~reset & (branch_taken | (flush_cnt_q != 2'd0));
  assign flush_id_ex = ~reset & branch_taken;

  assign advance = id_ok & ~stall & ~branch_taken;

  always_comb begin
    ex_d     = '0;
    fwd_a_d  = 2'b00;
    fwd_b_d  = 2'b00;
    if (advance) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = id_rd;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      // EX-slot producer is younger, so it wins over MEM.
      fwd_a_d = ex_m_rs1 ? 2'b10 : (mem_m_rs1 ? 2'b01 : 2'b00);
      fwd_b_d = ex_m_rs2 ? 2'b10 : (mem_m_rs2 ? 2'b01 : 2'b00);
    end
  end

  always_comb begin
    state_d = state_q;
    if (branch_taken) begin
      state_d = StRun;
    end else if (state_q == StLoadStall) begin
      state_d = StRun;
    end else if (load_use) begin
      state_d = StLoadStall;
    end
  end

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (branch_taken) begin
      flush_cnt_d = 2'(FLUSH_CYCLES);
    end else if (flush_cnt_q != 2'd0) begin
      flush_cnt_d = flush_cnt_q - 2'd1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((stall | flush_if_id) && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      state_q     <= StRun;
      flush_cnt_q <= 2'd0;
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      cnt_q       <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      cnt_q       <= cnt_d;
    end
  end

  assign fwd_a      = fwd_a_q;
  assign fwd_b      = fwd_b_q;
  assign hazard_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
module tb_hazard_forward_ctrl;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_regwrite, id_memread;
  logic       branch_taken;

  logic        stall, flush_if_id, flush_id_ex;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] hazard_cnt;

  logic        stall4, flush_if_id4, flush_id_ex4;
  logic [1:0]  fwd_a4, fwd_b4;
  logic [3:0]  hazard_cnt4;

  int vectors;
  int miscompares;

  hazard_forward_ctrl #(.REG_AW(5), .FLUSH_CYCLES(1), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .branch_taken (branch_taken),
    .stall        (stall),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .hazard_cnt   (hazard_cnt)
  );

  // Narrow-counter copy sharing the same stimulus, for saturation.
  hazard_forward_ctrl #(.REG_AW(5), .FLUSH_CYCLES(1), .CNT_W(4)) dut4 (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .branch_taken (branch_taken),
    .stall        (stall4),
    .flush_if_id  (flush_if_id4),
    .flush_id_ex  (flush_id_ex4),
    .fwd_a        (fwd_a4),
    .fwd_b        (fwd_b4),
    .hazard_cnt   (hazard_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one ID instruction.
  task automatic inst(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic rw, input logic mr);
    id_valid    = 1'b1;
    id_rd       = rd;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_use_rs1  = u1;
    id_use_rs2  = u2;
    id_regwrite = rw;
    id_memread  = mr;
  endtask

  task automatic nop();
    id_valid    = 1'b0;
    id_rd       = 5'd0;
    id_rs1      = 5'd0;
    id_rs2      = 5'd0;
    id_use_rs1  = 1'b0;
    id_use_rs2  = 1'b0;
    id_regwrite = 1'b0;
    id_memread  = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    nop();
    // Reset held with a branch pending: outputs must stay quiet.
    reset        = 1'b1;
    branch_taken = 1'b1;
    settle();
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_flush_if_id", 32'(flush_if_id), 32'd0);
    check("rst_flush_id_ex", 32'(flush_id_ex), 32'd0);
    tick();
    reset        = 1'b0;
    branch_taken = 1'b0;
    settle();
    check("rst_fwd_a", 32'(fwd_a), 32'd0);
    check("rst_fwd_b", 32'(fwd_b), 32'd0);
    check("rst_cnt", 32'(hazard_cnt), 32'd0);
    check("rst_flush_after", 32'(flush_if_id), 32'd0);
    tick();

    // add x5 ; sub x6,x5,x5 -> 10/10
    inst(5'd5, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    inst(5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0); settle();
    check("fwd_ex_stall", 32'(stall), 32'd0); tick();
    nop(); settle();
    check("fwd_ex_a", 32'(fwd_a), 32'h2);
    check("fwd_ex_b", 32'(fwd_b), 32'h2); tick();

    // add x5 ; add x9,x1,x2 ; sub x6,x5,x5 -> 01/01
    inst(5'd5, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    inst(5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    inst(5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0); settle();
    check("fwd_mem_stall", 32'(stall), 32'd0); tick();
    nop(); settle();
    check("fwd_mem_a", 32'(fwd_a), 32'h1);
    check("fwd_mem_b", 32'(fwd_b), 32'h1); tick();

    // x5 written in both EX and MEM -> EX wins
    inst(5'd5, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    inst(5'd5, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    inst(5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0); settle();
    check("fwd_pri_stall", 32'(stall), 32'd0); tick();
    nop(); settle();
    check("fwd_pri_a", 32'(fwd_a), 32'h2);
    check("fwd_pri_b", 32'(fwd_b), 32'h2);
    check("fwd_cnt", 32'(hazard_cnt), 32'd0); tick();
    tick();

    // lw x7 ; add x8,x7,x1 -> one stall, then 01/00
    inst(5'd7, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    inst(5'd8, 5'd7, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0); settle();
    check("lu_stall", 32'(stall), 32'd1);
    check("lu_flush", 32'(flush_if_id), 32'd0); tick();
    settle();
    check("lu_stall_once", 32'(stall), 32'd0); tick();
    nop(); settle();
    check("lu_fwd_a", 32'(fwd_a), 32'h1);
    check("lu_fwd_b", 32'(fwd_b), 32'h0);
    check("lu_cnt", 32'(hazard_cnt), 32'd1); tick();

    // lw x0 ; user of x0 -> nothing
    inst(5'd0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    inst(5'd8, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0); settle();
    check("x0_stall", 32'(stall), 32'd0); tick();
    nop(); settle();
    check("x0_fwd_a", 32'(fwd_a), 32'h0);
    check("x0_fwd_b", 32'(fwd_b), 32'h0); tick();

    // rs2 matches but is not read -> fwd_b stays 00
    inst(5'd5, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    inst(5'd6, 5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    nop(); settle();
    check("nouse_fwd_b", 32'(fwd_b), 32'h0);
    check("nouse_fwd_a", 32'(fwd_a), 32'h0);
    check("nouse_cnt", 32'(hazard_cnt), 32'd1); tick();
    tick();

    // Taken branch coinciding with a load-use hazard
    inst(5'd7, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    inst(5'd8, 5'd7, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    branch_taken = 1'b1; settle();
    check("br_stall", 32'(stall), 32'd0);
    check("br_flush_if_id0", 32'(flush_if_id), 32'd1);
    check("br_flush_id_ex0", 32'(flush_id_ex), 32'd1); tick();
    branch_taken = 1'b0; settle();
    check("br_flush_if_id1", 32'(flush_if_id), 32'd1);
    check("br_flush_id_ex1", 32'(flush_id_ex), 32'd0);
    check("br_stall1", 32'(stall), 32'd0); tick();
    nop(); settle();
    check("br_flush_if_id2", 32'(flush_if_id), 32'd0);
    check("br_fwd_a", 32'(fwd_a), 32'h0);
    check("br_cnt", 32'(hazard_cnt), 32'd3); tick();
    tick();

    // 20 load-use stalls: the 4-bit counter saturates
    for (int i = 0; i < 20; i++) begin
      inst(5'd7, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1); tick();
      inst(5'd8, 5'd7, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0); tick();
      tick();
    end
    nop(); settle();
    check("sat_cnt4", 32'(hazard_cnt4), 32'd15);
    check("sat_cnt16", 32'(hazard_cnt), 32'd23); tick();

    // Reset asserted while in the load-stall state
    inst(5'd7, 5'd1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    inst(5'd8, 5'd7, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0); settle();
    check("rs_pre_stall", 32'(stall), 32'd1); tick();
    reset = 1'b1; tick();
    reset = 1'b0; settle();
    check("rs_stall", 32'(stall), 32'd0);
    check("rs_fwd_a", 32'(fwd_a), 32'h0);
    check("rs_fwd_b", 32'(fwd_b), 32'h0);
    check("rs_cnt", 32'(hazard_cnt), 32'd0);
    check("rs_cnt4", 32'(hazard_cnt4), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
